// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor. Computes diff = (a - b) mod
//            2^WIDTH one bit per clock, LSB first, through a single
//            full-subtractor cell with a registered borrow. A start/busy/done
//            handshake frames each operation.
// Ports    : clk     - system clock, rising edge active
//            rst_n   - asynchronous active-low reset
//            start   - request a new subtraction (sampled on clk rise)
//            a, b    - minuend / subtrahend, latched when start is accepted
//            busy    - high while bits are being processed
//            done    - one-cycle pulse when diff/borrow are updated
//            diff    - result register, (a - b) mod 2^WIDTH
//            borrow  - final borrow out, 1 exactly when a < b (unsigned)
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // A 1-bit counter is kept for WIDTH=1 so the vector never collapses to
    // zero width; it simply stays at 0, which is also the last-bit index.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_wd;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_wd_next;

    // Full-subtractor cell on the current LSBs.
    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

    // Each new difference bit enters at the MSB, so after WIDTH shifts the
    // first (LSB) bit has walked down to bit 0.
    generate
        if (WIDTH > 1) begin : g_multi_bit
            assign w_wd_next = {w_d, r_wd[WIDTH-1:1]};
        end else begin : g_single_bit
            assign w_wd_next = w_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_wd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new request exactly like IDLE so that
                // back-to-back operations lose no cycle.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_wd    <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                // start is not looked at here: requests while busy are dropped.
                SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_wd  <= w_wd_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_BIT) begin
                        diff    <= w_wd_next;
                        borrow  <= w_br_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
